// File: rtl/arm_banked_regfile_if.sv
// arm_banked_regfile_if -- request/response bundle for the banked register file.
// The master issues two read requests and one write per cycle; the slave
// (the register file) returns registered read data with a one-cycle valid.
interface arm_banked_regfile_if #(
    parameter int DATA_W = 32
);
    logic              ra_en;
    logic [4:0]        ra_idx;
    logic              rb_en;
    logic [4:0]        rb_idx;
    logic              we;
    logic [4:0]        w_idx;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ra_data;
    logic              ra_vld;
    logic [DATA_W-1:0] rb_data;
    logic              rb_vld;

    modport master (
        output ra_en, ra_idx, rb_en, rb_idx, we, w_idx, wdata,
        input  ra_data, ra_vld, rb_data, rb_vld
    );

    modport slave (
        input  ra_en, ra_idx, rb_en, rb_idx, we, w_idx, wdata,
        output ra_data, ra_vld, rb_data, rb_vld
    );
endinterface

// File: rtl/arm_banked_regfile.sv
// arm_banked_regfile -- 31-entry physical register file behind the ARM
// mode/address bank mapper. Two independent read ports with one cycle of
// latency, one write port. Index 31 is the unused slot: writes to it are
// dropped and reads of it return zero.
//
// Build option: define REGFILE_WR_BYPASS_EN to forward same-cycle write data
// to a read of the same index; without it such a read sees the old value.
module arm_banked_regfile #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arm_banked_regfile_if.slave   bus
);

    localparam logic [4:0] LAST_IDX = 5'd31;
    localparam int         ENTRIES  = 31;

    logic [DATA_W-1:0] mem [0:ENTRIES-1];

    logic [DATA_W-1:0] ra_next_p0;
    logic [DATA_W-1:0] rb_next_p0;
    logic [DATA_W-1:0] ra_data_p1;
    logic [DATA_W-1:0] rb_data_p1;
    logic              vld_a_p1;
    logic              vld_b_p1;

    // Storage update: whole array clears on reset, unused slot ignores writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.we && (bus.w_idx != LAST_IDX)) begin
            mem[bus.w_idx] <= bus.wdata;
        end
    end

    // Read port A lookup (p0): zero for the unused slot, optional write forwarding.
    always_comb begin
        ra_next_p0 = '0;
        if (bus.ra_idx != LAST_IDX) begin
            ra_next_p0 = mem[bus.ra_idx];
`ifdef REGFILE_WR_BYPASS_EN
            if (bus.we && (bus.w_idx == bus.ra_idx)) begin
                ra_next_p0 = bus.wdata;
            end
`endif
        end
    end

    // Read port B lookup (p0): same rules as port A, fully independent.
    always_comb begin
        rb_next_p0 = '0;
        if (bus.rb_idx != LAST_IDX) begin
            rb_next_p0 = mem[bus.rb_idx];
`ifdef REGFILE_WR_BYPASS_EN
            if (bus.we && (bus.w_idx == bus.rb_idx)) begin
                rb_next_p0 = bus.wdata;
            end
`endif
        end
    end

    // p0 -> p1: capture read results; data holds when the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_data_p1 <= '0;
            rb_data_p1 <= '0;
            vld_a_p1   <= 1'b0;
            vld_b_p1   <= 1'b0;
        end else begin
            vld_a_p1 <= bus.ra_en;
            vld_b_p1 <= bus.rb_en;
            if (bus.ra_en) begin
                ra_data_p1 <= ra_next_p0;
            end
            if (bus.rb_en) begin
                rb_data_p1 <= rb_next_p0;
            end
        end
    end

    assign bus.ra_data = ra_data_p1;
    assign bus.ra_vld  = vld_a_p1;
    assign bus.rb_data = rb_data_p1;
    assign bus.rb_vld  = vld_b_p1;

endmodule

// File: doc/arm_banked_regfile.md
ARM_BANKED_REGFILE -- requirements
Module: arm_banked_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous assertion, active-low.
REQ-004 The block SHALL have port ra_en, input, 1 bit, read port A request.
REQ-005 The block SHALL have port ra_idx, input, 5 bits, physical register index for read port A, as produced by the mode/address bank mapper.
REQ-006 The block SHALL have port rb_en, input, 1 bit, read port B request.
REQ-007 The block SHALL have port rb_idx, input, 5 bits, physical register index for read port B.
REQ-008 The block SHALL have port we, input, 1 bit, write request.
REQ-009 The block SHALL have port w_idx, input, 5 bits, physical register index to write.
REQ-010 The block SHALL have port wdata, input, DATA_W bits, write data.
REQ-011 The block SHALL have port ra_data, output, DATA_W bits, registered read data for port A.
REQ-012 The block SHALL have port ra_vld, output, 1 bit, high for one cycle when ra_data carries a new result.
REQ-013 The block SHALL have port rb_data, output, DATA_W bits, registered read data for port B.
REQ-014 The block SHALL have port rb_vld, output, 1 bit, high for one cycle when rb_data carries a new result.

Function
REQ-015 Storage SHALL be 31 physical entries, indices 0..30; index 31 is the unused slot.
REQ-016 A write with we=1 and w_idx<=30 SHALL update entry w_idx at the rising edge of clk.
REQ-017 A write with we=1 and w_idx=31 SHALL change no storage.
REQ-018 Read latency SHALL be 1 cycle: ra_en=1 in cycle N gives ra_data and ra_vld=1 in cycle N+1; port B behaves identically and independently.
REQ-019 When ra_en=0, ra_vld SHALL be 0 next cycle and ra_data SHALL hold its previous value; port B likewise.
REQ-020 A read of index 31 SHALL return all-zero data with the vld bit asserted.
REQ-021 Both ports SHALL be allowed to read the same index in the same cycle and SHALL return identical data.
REQ-022 A read and a write to the same index in the same cycle SHALL follow REQ-028/REQ-029.
REQ-023 Reads and writes to different indices in the same cycle SHALL not interact.

Reset
REQ-024 While rst_n=0, all 31 entries SHALL be 0, independent of clk.
REQ-025 While rst_n=0, ra_data, rb_data, ra_vld and rb_vld SHALL be 0.
REQ-026 A request present in the cycle rst_n is asserted SHALL be discarded and SHALL not complete after reset release.
REQ-027 The first rising edge of clk with rst_n=1 SHALL process requests normally.

Configuration
REQ-028 With macro REGFILE_WR_BYPASS_EN defined, a read of index i in the same cycle as a write to i (i<=30) SHALL return the new wdata one cycle later.
REQ-029 Without REGFILE_WR_BYPASS_EN, that read SHALL return the pre-write value; the written value SHALL be visible from the next-cycle read onward.

Verification
REQ-030 The bench SHALL cover: release reset; ra_en=1, ra_idx=5 -> next cycle ra_data=0, ra_vld=1.
REQ-031 The bench SHALL cover: write idx 17 = 0xDEADBEEF; next cycle ra_idx=17, rb_idx=17 -> both ports return 0xDEADBEEF with vld=1.
REQ-032 The bench SHALL cover: idx 3 = 0x11; same cycle we idx 3 = 0x22 and ra_idx=3 -> ra_data=0x22 with REGFILE_WR_BYPASS_EN, 0x11 without; following read -> 0x22 in both builds.
REQ-033 The bench SHALL cover: write idx 31 = 0xFFFFFFFF, then read idx 31 and every idx 0..30 -> 0 everywhere, vld=1.
REQ-034 The bench SHALL cover: fill all 31 entries with value idx*0x01010101; assert rst_n=0 mid-clock with ra_en=1 pending -> outputs 0 immediately; after release, all reads return 0 and no stale ra_vld pulse appears.
